// File: rtl/led_bar_meter.sv
// -----------------------------------------------------------------------------
// led_bar_meter
//
// LED bar-graph meter for an N-segment column. A quantised level (note index or
// magnitude) is mapped to a target bar height; the displayed height rises
// one segment per animation tick and falls one segment every DECAY_TICKS ticks.
// A peak marker holds for PEAK_HOLD_TICKS ticks, then falls one segment per
// tick until it is refreshed by the bar. Four display modes are supported.
//
// Ports
//   clk          clock
//   rstn         synchronous active-low reset
//   level_in     quantised level / note index (LEVEL_W bits)
//   level_valid  1 = level_in meaningful, 0 = silence (target height 0)
//   mode         00 bar, 01 dot, 10 bar + peak marker, 11 blank
//   freeze       1 = animation state holds; target and led still update
//   led          registered LED drive; led[NUM_LEDS-1] is the bottom segment
//   level_out    current bar height (0..NUM_LEDS)
//   peak_out     current peak-marker height (0..NUM_LEDS)
// -----------------------------------------------------------------------------
module led_bar_meter #(
   parameter int unsigned NUM_LEDS        = 6,
   parameter int unsigned LEVEL_W         = 4,
   parameter int unsigned LEVEL_SHIFT     = 1,
   parameter int unsigned TICK_DIV        = 166667,
   parameter int unsigned DECAY_TICKS     = 2,
   parameter int unsigned PEAK_HOLD_TICKS = 30,
   localparam int unsigned HW             = $clog2(NUM_LEDS + 1)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [LEVEL_W-1:0]  level_in,
   input  logic                level_valid,
   input  logic [1:0]          mode,
   input  logic                freeze,
   output logic [NUM_LEDS-1:0] led,
   output logic [HW-1:0]       level_out,
   output logic [HW-1:0]       peak_out
);

   // Counter widths; a terminal count of 1 still needs a 1-bit register.
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
   localparam int unsigned KW = (PEAK_HOLD_TICKS > 1) ? $clog2(PEAK_HOLD_TICKS) : 1;
   // Target arithmetic width: at least 32 bits, and one more than LEVEL_W so
   // the +1 can never wrap before the saturation compare.
   localparam int unsigned SW = (LEVEL_W >= 32) ? LEVEL_W + 1 : 32;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DECAY_MAX = DW'(DECAY_TICKS - 1);
   localparam logic [KW-1:0] HOLD_MAX  = KW'(PEAK_HOLD_TICKS - 1);
   localparam logic [HW-1:0] FULL_H    = HW'(NUM_LEDS);
   localparam logic [SW-1:0] FULL_S    = SW'(NUM_LEDS);

   typedef enum logic [1:0] {
      ModeBar     = 2'b00,
      ModeDot     = 2'b01,
      ModeBarPeak = 2'b10,
      ModeBlank   = 2'b11
   } mode_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [HW-1:0]       target_q, target_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [HW-1:0]       cur_q, cur_d;
   logic [HW-1:0]       peak_q, peak_d;
   logic [DW-1:0]       decay_q, decay_d;
   logic [KW-1:0]       hold_q, hold_d;
   logic [NUM_LEDS-1:0] led_q, led_d;

   logic                tick;
   logic                tick_eff;

   // ---------------------------------------------------------------------------
   // Target height: silence maps to 0, otherwise (level >> shift) + 1,
   // saturated at the column height.
   // ---------------------------------------------------------------------------
   logic [SW-1:0] lvl_sum;

   assign lvl_sum = SW'(level_in >> LEVEL_SHIFT) + SW'(1);

   always_comb begin
      target_d = '0;
      if (level_valid) begin
         if (lvl_sum >= FULL_S) begin
            target_d = FULL_H;
         end else begin
            target_d = HW'(lvl_sum);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Free-running tick prescaler; unaffected by freeze or target changes so
   // the tick phase is preserved across a freeze.
   // ---------------------------------------------------------------------------
   assign tick     = (presc_q == PRESC_MAX);
   assign tick_eff = tick & ~freeze;

   always_comb begin
      presc_d = presc_q + PW'(1);
      if (tick) begin
         presc_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Bar height animation: fast attack, divided decay. Uses the registered
   // target, so a target change in a tick cycle only counts from the next tick.
   // ---------------------------------------------------------------------------
   always_comb begin
      cur_d   = cur_q;
      decay_d = decay_q;
      if (cur_q < target_q) begin
         cur_d   = cur_q + HW'(1);
         decay_d = '0;
      end else if (cur_q > target_q) begin
         if (decay_q == DECAY_MAX) begin
            cur_d   = cur_q - HW'(1);
            decay_d = '0;
         end else begin
            decay_d = decay_q + DW'(1);
         end
      end else begin
         decay_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Peak marker, driven by the next bar height. While below the bar-to-be it
   // is refreshed; otherwise it holds, then falls one segment per tick. Since
   // cur_d < peak_q in the falling branch, peak_q - 1 can never drop below it.
   // ---------------------------------------------------------------------------
   always_comb begin
      peak_d = peak_q;
      hold_d = hold_q;
      if (cur_d >= peak_q) begin
         peak_d = cur_d;
         hold_d = '0;
      end else if (hold_q < HOLD_MAX) begin
         hold_d = hold_q + KW'(1);
      end else begin
         peak_d = peak_q - HW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // LED mapping from the registered heights. Height h lights the bottom h
   // segments, i.e. led[NUM_LEDS-1 : NUM_LEDS-h]; the single-dot form lights
   // only led[NUM_LEDS-h].
   // ---------------------------------------------------------------------------
   logic [NUM_LEDS-1:0] bar_cur;
   logic [NUM_LEDS-1:0] dot_cur;
   logic [NUM_LEDS-1:0] dot_peak;

   always_comb begin
      bar_cur  = '0;
      dot_cur  = '0;
      dot_peak = '0;
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
         bar_cur[i]  = (i + int'(cur_q)) >= int'(NUM_LEDS);
         dot_cur[i]  = (cur_q != '0) && ((i + int'(cur_q)) == int'(NUM_LEDS));
         dot_peak[i] = (peak_q != '0) && ((i + int'(peak_q)) == int'(NUM_LEDS));
      end
   end

   always_comb begin
      led_d = '0;
      unique case (mode_e'(mode))
         ModeBar:     led_d = bar_cur;
         ModeDot:     led_d = dot_cur;
         ModeBarPeak: led_d = bar_cur | dot_peak;
         ModeBlank:   led_d = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         target_q <= '0;
         presc_q  <= '0;
         cur_q    <= '0;
         peak_q   <= '0;
         decay_q  <= '0;
         hold_q   <= '0;
         led_q    <= '0;
      end else begin
         target_q <= target_d;
         presc_q  <= presc_d;
         led_q    <= led_d;
         if (tick_eff) begin
            cur_q   <= cur_d;
            decay_q <= decay_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
         end
      end
   end

   assign led       = led_q;
   assign level_out = cur_q;
   assign peak_out  = peak_q;

endmodule

// File: tb/tb_led_bar_meter.sv
// -----------------------------------------------------------------------------
// tb_led_bar_meter
//
// Two meters share one stimulus stream: one with a 4-cycle tick and one that
// ticks every cycle. A reference model computes the expected outputs from the
// behavioural rules; expectations are queued per clock and a separate monitor
// compares them against both meters on the falling edge.
// -----------------------------------------------------------------------------
module tb_led_bar_meter;

   localparam int N   = 6;
   localparam int DT  = 2;
   localparam int PHT = 3;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] level_in;
   logic       level_valid;
   logic [1:0] mode;
   logic       freeze;

   logic [5:0] led1, led2;
   logic [2:0] lvl1, lvl2;
   logic [2:0] pk1, pk2;

   always #5 clk = ~clk;

   led_bar_meter #(
      .NUM_LEDS       (N),
      .LEVEL_W        (4),
      .LEVEL_SHIFT    (1),
      .TICK_DIV       (4),
      .DECAY_TICKS    (DT),
      .PEAK_HOLD_TICKS(PHT)
   ) u_dut_div4 (
      .clk        (clk),
      .rstn       (rstn),
      .level_in   (level_in),
      .level_valid(level_valid),
      .mode       (mode),
      .freeze     (freeze),
      .led        (led1),
      .level_out  (lvl1),
      .peak_out   (pk1)
   );

   led_bar_meter #(
      .NUM_LEDS       (N),
      .LEVEL_W        (4),
      .LEVEL_SHIFT    (1),
      .TICK_DIV       (1),
      .DECAY_TICKS    (DT),
      .PEAK_HOLD_TICKS(PHT)
   ) u_dut_div1 (
      .clk        (clk),
      .rstn       (rstn),
      .level_in   (level_in),
      .level_valid(level_valid),
      .mode       (mode),
      .freeze     (freeze),
      .led        (led2),
      .level_out  (lvl2),
      .peak_out   (pk2)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct {
      int target;
      int cyc;     // clock edges since reset; ticks fall on cyc % div == div-1
      int cur;
      int peak;
      int above;   // ticks spent above target since the last downward step
      int held;    // ticks the peak has been left behind by the bar
      int led;
   } mstate_t;

   typedef struct {
      int led1, cur1, pk1;
      int led2, cur2, pk2;
   } exp_t;

   mstate_t m1, m2;
   exp_t    exp_q[$];
   exp_t    e;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int bar_of(int h);
      return ((1 << h) - 1) << (N - h);
   endfunction

   function automatic int dot_of(int h);
      return (h == 0) ? 0 : (1 << (N - h));
   endfunction

   function automatic int led_of(int cur, int peak, int md);
      case (md)
         0:       return bar_of(cur);
         1:       return dot_of(cur);
         2:       return bar_of(cur) | dot_of(peak);
         default: return 0;
      endcase
   endfunction

   function automatic mstate_t model_step(mstate_t s, int div, bit r, int lvl, bit vld,
                                          int md, bit frz);
      mstate_t n;
      int      h;
      n = s;
      if (!r) begin
         n = '{default: 0};
         return n;
      end
      h        = (lvl >> 1) + 1;
      n.target = vld ? ((h > N) ? N : h) : 0;
      n.cyc    = s.cyc + 1;
      n.led    = led_of(s.cur, s.peak, md);
      if (((s.cyc % div) == div - 1) && !frz) begin
         n.above = 0;
         if (s.cur < s.target) begin
            n.cur = s.cur + 1;
         end else if (s.cur > s.target) begin
            if (s.above + 1 >= DT) n.cur = s.cur - 1;
            else n.above = s.above + 1;
         end
         if (n.cur >= s.peak) begin
            n.peak = n.cur;
            n.held = 0;
         end else if (s.held + 1 < PHT) begin
            n.held = s.held + 1;
         end else begin
            n.peak = s.peak - 1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model the edge from the inputs now applied, queue the expected
   // result after the edge, then return just after the following falling edge.
   task automatic run(input int cycles);
      exp_t x;
      for (int k = 0; k < cycles; k++) begin
         m1 = model_step(m1, 4, rstn, int'(level_in), level_valid, int'(mode), freeze);
         m2 = model_step(m2, 1, rstn, int'(level_in), level_valid, int'(mode), freeze);
         x  = '{m1.led, m1.cur, m1.peak, m2.led, m2.cur, m2.peak};
         @(posedge clk);
         exp_q.push_back(x);
         @(negedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("div4 led",       int'(led1), e.led1);
         chk("div4 level_out", int'(lvl1), e.cur1);
         chk("div4 peak_out",  int'(pk1),  e.pk1);
         chk("div1 led",       int'(led2), e.led2);
         chk("div1 level_out", int'(lvl2), e.cur2);
         chk("div1 peak_out",  int'(pk2),  e.pk2);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int  waited;
      bit  found;
      m1 = '{default: 0};
      m2 = '{default: 0};
      rstn        = 1'b0;
      level_in    = '0;
      level_valid = 1'b0;
      mode        = 2'b00;
      freeze      = 1'b0;
      @(negedge clk);
      #1;

      // Reset and idle
      run(3);
      chk("reset led", int'(led1), 0);
      chk("reset level_out", int'(lvl1), 0);
      chk("reset peak_out", int'(pk1), 0);
      rstn = 1'b1;
      run(50);
      chk("idle level_out", int'(lvl1), 0);
      chk("idle led", int'(led1), 0);

      // Attack to full scale, then over-range levels
      level_valid = 1'b1;
      level_in    = 4'd11;
      run(30);
      chk("attack level_out", int'(lvl1), 6);
      chk("attack led", int'(led1), 6'b111111);
      chk("attack peak_out", int'(pk1), 6);
      chk("attack div1 level_out", int'(lvl2), 6);
      level_in = 4'd15;
      run(8);
      chk("sat level_out", int'(lvl1), 6);

      // Decay with peak hold
      mode     = 2'b10;
      level_in = 4'd0;
      run(60);
      chk("decay level_out", int'(lvl1), 1);
      chk("decay peak_out", int'(pk1), 1);
      chk("decay led", int'(led1), 6'b100000);

      // Dot, blank and mode switching at height 4
      mode     = 2'b00;
      level_in = 4'd6;
      run(20);
      chk("mid level_out", int'(lvl1), 4);
      mode = 2'b01;
      run(1);
      chk("dot led", int'(led1), 6'b000100);
      mode = 2'b11;
      run(1);
      chk("blank led", int'(led1), 0);
      mode = 2'b00;
      run(1);
      chk("bar led", int'(led1), 6'b111100);

      // Freeze during attack at height 3
      rstn = 1'b0;
      run(2);
      rstn     = 1'b1;
      level_in = 4'd11;
      found    = 1'b0;
      waited   = 0;
      while (!found && waited < 40) begin
         run(1);
         waited++;
         if (lvl1 == 3'd3) found = 1'b1;
      end
      chk("reach height 3", int'(found), 1);
      freeze = 1'b1;
      run(20);
      chk("freeze level_out", int'(lvl1), 3);
      freeze = 1'b0;
      run(20);
      chk("unfreeze level_out", int'(lvl1), 6);

      // Reset in the middle of a decay
      mode     = 2'b10;
      level_in = 4'd0;
      run(7);
      rstn = 1'b0;
      run(1);
      chk("midreset led", int'(led1), 0);
      chk("midreset level_out", int'(lvl1), 0);
      chk("midreset peak_out", int'(pk1), 0);
      chk("midreset div1 peak_out", int'(pk2), 0);
      rstn = 1'b1;

      // Randomised segments of held inputs
      for (int seg = 0; seg < 160; seg++) begin
         level_in    = 4'($urandom_range(0, 15));
         level_valid = ($urandom_range(0, 3) != 0);
         mode        = 2'($urandom_range(0, 3));
         freeze      = ($urandom_range(0, 5) == 0);
         rstn        = ($urandom_range(0, 39) != 0);
         if (!rstn) begin
            run(1);
            rstn = 1'b1;
         end
         run($urandom_range(1, 25));
      end

      run(2);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_bar_meter.md
Name: led_bar_meter

Overview:
Parametrised LED bar-graph meter. Drives an N-segment LED column from a quantised audio level (note index or magnitude). Bar height animates one segment per tick on attack, with slower configurable decay. Adds a peak-hold indicator and selectable display modes; sits between the note/level detector and the board LED pins.

Parameters:
NUM_LEDS, 6, number of LED segments (>=2)
LEVEL_W, 4, width of level_in
LEVEL_SHIFT, 1, right-shift applied to level_in before mapping to height
TICK_DIV, 166667, clk cycles per animation tick (>=1)
DECAY_TICKS, 2, ticks per one-segment decrease of the bar (>=1)
PEAK_HOLD_TICKS, 30, ticks the peak marker holds before falling (>=1)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
level_in  input  LEVEL_W  quantised level / note index
level_valid  input  1  1 = level_in meaningful; 0 = silence
mode  input  2  00 bar, 01 dot, 10 bar+peak, 11 blank
freeze  input  1  1 = hold current display, ignore ticks
led  output  NUM_LEDS  LED drive, registered
level_out  output  HW  current bar height, HW = $clog2(NUM_LEDS+1)
peak_out  output  HW  current peak-marker height

Behaviour:
- Reset (rstn=0 at posedge): led, level_out (cur), peak_out (peak), target, prescaler, decay_cnt, hold_cnt all 0 on that edge. Reset mid-animation aborts immediately; no residual state.
- Target register, updated every cycle: level_valid=0 -> 0; else min((level_in >> LEVEL_SHIFT) + 1, NUM_LEDS), computed wide enough not to overflow. Defaults: 0..1->1, ... 10..11->6, 12..15->6.
- Prescaler counts 0..TICK_DIV-1 free-running and wraps; tick is a one-cycle pulse when count == TICK_DIV-1. TICK_DIV=1 -> tick every cycle. Prescaler is not affected by target changes or freeze.
- Effective tick = tick & ~freeze. All cur/peak/decay/hold updates happen only on effective ticks and use the registered target (a target change in the tick cycle takes effect on the next tick).
- Attack: cur < target -> cur+1; decay_cnt <= 0.
- Decay: cur > target -> if decay_cnt == DECAY_TICKS-1 then cur-1, decay_cnt <= 0; else decay_cnt+1.
- cur == target -> cur holds, decay_cnt <= 0.
- Peak (uses next-cur value n): n >= peak -> peak <= n, hold_cnt <= 0. Else if hold_cnt < PEAK_HOLD_TICKS-1 -> hold_cnt+1; else peak <= peak-1 (never below n), hold_cnt stays saturated until peak is refreshed.
- cur and peak are bounded to 0..NUM_LEDS; no wrap.
- LED map (registered, one cycle after cur/peak change). Bit led[NUM_LEDS-1] is the bottom segment; height h lights led[NUM_LEDS-1 : NUM_LEDS-h].
  - mode 00: bar of height cur.
  - mode 01: only bit NUM_LEDS-cur (all off if cur=0).
  - mode 10: bar of cur OR single bit NUM_LEDS-peak (if peak>0).
  - mode 11: all 0.
  - Mode changes affect led on the next edge, independent of ticks.
- level_out = cur, peak_out = peak, both registered, no extra latency.
- freeze=1: cur, peak, decay_cnt, hold_cnt hold; target and led (incl. mode) still update.

Test Plan:
- Reset/idle, bench TICK_DIV=4, defaults otherwise: rstn low 3 cycles -> led=0, level_out=0, peak_out=0; with level_valid=0, all stay 0 over 50 cycles.
- Attack: level_valid=1, level_in=11, mode 00 -> level_out steps 1..6, one per tick (every 4 cycles); led reaches 6'b111111, first lit bit is led[5]; 12..15 also saturate at 6.
- Decay and peak: from height 6, set level_in=0 (target 1) with DECAY_TICKS=2, PEAK_HOLD_TICKS=3, mode 10 -> cur falls one per 2 ticks to 1; peak stays 6 for 3 ticks, then falls 1/tick; peak bit visible above bar, e.g. cur=3, peak=5 -> led=6'b111010.
- Dot/blank/mode switch: cur=4, mode 01 -> led=6'b000100; mode 11 -> 0 on the next edge; back to 00 -> 6'b111100 with no tick needed.
- Freeze: freeze=1 while attacking at cur=3 toward 6 for 20 cycles -> level_out stays 3; on release, resumes at the next tick boundary (prescaler phase unchanged).
- Edge cases: TICK_DIV=1 -> one step per cycle; target change in the tick cycle -> old target used, new one next tick; rstn pulse mid-decay -> all outputs 0 on the next edge.
